// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants and helpers for the round-robin bus matrix
// Contents: default widths, default two-slave address map, arbiter state type,
//           round-robin next-owner search, lowest-set-bit one-hot.
package bus_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 64;

    // Slave 1 at 0x01xx, slave 0 at 0x00xx.
    localparam logic [2*DEF_AW-1:0] DEF_SLAVE_BASE = {16'h0100, 16'h0000};
    localparam logic [2*DEF_AW-1:0] DEF_SLAVE_MASK = {16'hFF00, 16'hFF00};

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    // First requester scanning last+1, last+2, ... modulo n; -1 when none.
    // The scan wraps back to 'last' itself as the final candidate.
    function automatic int rr_pick(input logic [7:0] req, input int last, input int n);
        int idx;
        int found;
        found = -1;
        for (int i = 1; i <= 8; i++) begin
            if (i <= n && found < 0) begin
                idx = (last + i) % n;
                if (req[3'(idx)]) begin
                    found = idx;
                end
            end
        end
        return found;
    endfunction

    // Isolates the lowest set bit (two's complement trick).
    function automatic logic [7:0] lsb_onehot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/bus_rr_arbit.sv
// rtl/bus_rr_arbit.sv - registered round-robin arbiter, non-preemptive
// Ports: clk, reset (sync, active-high), m_req[N_MASTER] requests in,
//        m_grant[N_MASTER] one-hot (or zero) grant out, decoded from registered state.
module bus_rr_arbit
    import bus_pkg::*;
#(
    parameter int N_MASTER = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_MASTER-1:0] m_req,
    output logic [N_MASTER-1:0] m_grant
);

    localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    arb_state_t    state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last_owner, last_owner_n;
    int            pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_owner <= IW'(N_MASTER - 1);
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        pick         = -1;
        case (state)
            ARB_IDLE: begin
                pick = rr_pick(8'(m_req), int'(last_owner), N_MASTER);
                if (pick >= 0) begin
                    state_n = ARB_OWN;
                    owner_n = IW'(pick);
                end
            end
            ARB_OWN: begin
                // Release only on a dropped request; hand over directly to the
                // next requester so ownership changes cost no dead cycle.
                if (!m_req[owner]) begin
                    last_owner_n = owner;
                    pick = rr_pick(8'(m_req), int'(owner), N_MASTER);
                    if (pick >= 0) begin
                        owner_n = IW'(pick);
                    end else begin
                        state_n = ARB_IDLE;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_comb begin
        m_grant = '0;
        if (state == ARB_OWN) begin
            m_grant[owner] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_rr_matrix.sv
// rtl/bus_rr_matrix.sv - N-master / N-slave shared bus with round-robin arbitration
// Ports: clk, reset (sync, active-high);
//        masters: m_req, m_wr, m_addr, m_dout in; m_grant, m_din, m_err out;
//        slaves:  s_sel, s_addr, s_wr, s_din out; s_dout in.
module bus_rr_matrix
    import bus_pkg::*;
#(
    parameter int                      N_MASTER   = 2,
    parameter int                      N_SLAVE    = 2,
    parameter int                      AW         = DEF_AW,
    parameter int                      DW         = DEF_DW,
    parameter logic [N_SLAVE*AW-1:0]   SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [N_SLAVE*AW-1:0]   SLAVE_MASK = DEF_SLAVE_MASK
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_MASTER-1:0]    m_req,
    input  logic [N_MASTER-1:0]    m_wr,
    input  logic [N_MASTER*AW-1:0] m_addr,
    input  logic [N_MASTER*DW-1:0] m_dout,
    output logic [N_MASTER-1:0]    m_grant,
    output logic [DW-1:0]          m_din,
    output logic                   m_err,
    output logic [N_SLAVE-1:0]     s_sel,
    output logic [AW-1:0]          s_addr,
    output logic                   s_wr,
    output logic [DW-1:0]          s_din,
    input  logic [N_SLAVE*DW-1:0]  s_dout
);

    logic               grant_any;
    logic [N_SLAVE-1:0] hit;
    logic               unmapped;
    logic [N_SLAVE-1:0] rd_sel;
    logic               rd_err;

    bus_rr_arbit #(
        .N_MASTER (N_MASTER)
    ) u_arbit (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_grant (m_grant)
    );

    assign grant_any = |m_grant;

    // Owner mux; forced to zero when nobody owns the bus.
    always_comb begin
        s_addr = '0;
        s_wr   = 1'b0;
        s_din  = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (m_grant[k]) begin
                s_addr = m_addr[k*AW +: AW];
                s_wr   = m_wr[k];
                s_din  = m_dout[k*DW +: DW];
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            hit[i] = grant_any && ((s_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]);
        end
    end

    // Overlapping regions resolve to the lowest slave index.
    assign s_sel    = N_SLAVE'(lsb_onehot(8'(hit)));
    assign unmapped = grant_any & ~|hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sel <= '0;
            rd_err <= 1'b0;
        end else begin
            rd_sel <= s_sel & ~{N_SLAVE{s_wr}};
            rd_err <= unmapped;
        end
    end

    always_comb begin
        m_din = '0;
        for (int i = 0; i < N_SLAVE; i++) begin
            if (rd_sel[i]) begin
                m_din = m_din | s_dout[i*DW +: DW];
            end
        end
    end

    assign m_err = rd_err;

endmodule

// File: tb/tb_bus_rr_matrix.sv
// tb/tb_bus_rr_matrix.sv - scoreboard bench for bus_rr_matrix
module tb_bus_rr_matrix;
    import bus_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   m_req;
    logic [1:0]   m_wr;
    logic [15:0]  m0_addr, m1_addr;
    logic [63:0]  m0_dout, m1_dout;
    logic [1:0]   m_grant;
    logic [63:0]  m_din;
    logic         m_err;
    logic [1:0]   s_sel;
    logic [15:0]  s_addr;
    logic         s_wr;
    logic [63:0]  s_din;
    logic [63:0]  s0_dout, s1_dout;

    logic [31:0]  m_addr;
    logic [127:0] m_dout;
    logic [127:0] s_dout;

    assign m_addr = {m1_addr, m0_addr};
    assign m_dout = {m1_dout, m0_dout};
    assign s_dout = {s1_dout, s0_dout};

    always #5 clk = ~clk;

    bus_rr_matrix dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_wr    (m_wr),
        .m_addr  (m_addr),
        .m_dout  (m_dout),
        .m_grant (m_grant),
        .m_din   (m_din),
        .m_err   (m_err),
        .s_sel   (s_sel),
        .s_addr  (s_addr),
        .s_wr    (s_wr),
        .s_din   (s_din),
        .s_dout  (s_dout)
    );

    typedef struct {
        string       name;
        logic [1:0]  grant;
        logic [1:0]  sel;
        logic [15:0] addr;
        logic        wr;
        logic [63:0] sdin;
        logic [63:0] mdin;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input string n, input logic [1:0] g, input logic [1:0] sl,
                            input logic [15:0] a, input logic w, input logic [63:0] sd,
                            input logic [63:0] md, input logic e);
        exp_t x;
        x.name = n; x.grant = g; x.sel = sl; x.addr = a; x.wr = w;
        x.sdin = sd; x.mdin = md; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", n, f, act, want);
        end
    endtask

    // Monitor: every sampled cycle with a pending expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk(x.name, "m_grant", 64'(m_grant), 64'(x.grant));
            chk(x.name, "s_sel",   64'(s_sel),   64'(x.sel));
            chk(x.name, "s_addr",  64'(s_addr),  64'(x.addr));
            chk(x.name, "s_wr",    64'(s_wr),    64'(x.wr));
            chk(x.name, "s_din",   s_din,        x.sdin);
            chk(x.name, "m_din",   m_din,        x.mdin);
            chk(x.name, "m_err",   64'(m_err),   64'(x.err));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] D0 = 64'h1111;
    localparam logic [63:0] DB = 64'hDEAD_BEEF;
    localparam logic [63:0] RA = 64'hA;
    localparam logic [63:0] RB = 64'hB;

    initial begin
        reset   = 1'b1;
        m_req   = 2'b11;
        m_wr    = 2'b00;
        m0_addr = 16'h0010;
        m1_addr = 16'h0134;
        m0_dout = D0;
        m1_dout = DB;
        s0_dout = RA;
        s1_dout = RB;

        // Reset held three edges with both masters requesting.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) reset = 1'b0;
            push_exp($sformatf("reset%0d", i), 2'b00, 2'b00, 16'h0000, 1'b0, 64'h0, 64'h0, 1'b0);
        end

        // A: first post-reset edge grants master 0; read slave 0.
        next_cycle();
        m_wr[1] = 1'b1;
        push_exp("grant_m0_rd0", 2'b01, 2'b01, 16'h0010, 1'b0, D0, 64'h0, 1'b0);

        // B: master 0 still owns, drops req, reads slave 1; slave 0 data returns.
        next_cycle();
        m_req   = 2'b10;
        m0_addr = 16'h0120;
        push_exp("m0_rd1_release", 2'b01, 2'b10, 16'h0120, 1'b0, D0, RA, 1'b0);

        // C: handover to master 1 with no gap; write to slave 1; slave 1 read returns.
        next_cycle();
        push_exp("m1_wr_decode", 2'b10, 2'b10, 16'h0134, 1'b1, DB, RB, 1'b0);

        // D: master 1 reads an unmapped address; previous write returns nothing.
        next_cycle();
        m_req   = 2'b11;
        m_wr[1] = 1'b0;
        m1_addr = 16'h8000;
        push_exp("m1_unmapped", 2'b10, 2'b00, 16'h8000, 1'b0, DB, 64'h0, 1'b0);

        // E: master 1 drops req while still owner; error flag for D.
        next_cycle();
        m_req   = 2'b01;
        m1_addr = 16'h0120;
        push_exp("m1_release_err", 2'b10, 2'b10, 16'h0120, 1'b0, DB, 64'h0, 1'b1);

        // F: grant back to master 0; read slave 0; reset asserted in this address cycle.
        next_cycle();
        m0_addr = 16'h0010;
        reset   = 1'b1;
        push_exp("m0_back_rd0", 2'b01, 2'b01, 16'h0010, 1'b0, D0, RB, 1'b0);

        // G: reset edge killed both the grant and the in-flight read.
        next_cycle();
        reset = 1'b0;
        push_exp("reset_mid_read", 2'b00, 2'b00, 16'h0000, 1'b0, 64'h0, 64'h0, 1'b0);

        // H: master 0 regrants one edge after reset release; then drops req.
        next_cycle();
        m_req = 2'b00;
        push_exp("regrant_m0", 2'b01, 2'b01, 16'h0010, 1'b0, D0, 64'h0, 1'b0);

        // I: bus idle, broadcast zeroed, last read still returns.
        next_cycle();
        push_exp("idle_return", 2'b00, 2'b00, 16'h0000, 1'b0, 64'h0, RA, 1'b0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
